// File: rtl/pattern_seq.sv
// Programmable step sequencer: a prescaler paces a step index that walks a small
// writable pattern table forward or backward, and the indexed pattern is registered out.
module pattern_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned DIV_W = 16,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             run,
    input  logic             dir,
    input  logic             clr,
    input  logic [AW-1:0]    last_idx,
    input  logic [DIV_W-1:0] div,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] pat_out,
    output logic [AW-1:0]    step_idx,
    output logic             step_tick
);

    logic [DIV_W-1:0] pc_q, pc_d;
    logic [AW-1:0]    step_q, step_d, next_step;
    logic             tick_q, tick_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [WIDTH-1:0] table_q [DEPTH];

    // Power-on pattern set; only defined for 8-bit patterns.
    function automatic logic [WIDTH-1:0] dflt_entry(input int unsigned i);
        logic [7:0] v;
        case (i)
            0:       v = 8'h90;
            1:       v = 8'h18;
            2:       v = 8'h48;
            3:       v = 8'h60;
            4:       v = 8'h24;
            5:       v = 8'h84;
            default: v = 8'h00;
        endcase
        if (WIDTH == 8) return WIDTH'(v);
        return '0;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                table_q[i] <= dflt_entry(i);
            end
        end else if (ena && wr_en) begin
            table_q[wr_addr] <= wr_data;
        end
    end

    // Out-of-range indices (after last_idx shrinks) fold back into the active range.
    always_comb begin
        if (!dir) begin
            next_step = (step_q >= last_idx) ? '0 : step_q + AW'(1);
        end else begin
            next_step = (step_q == '0 || step_q > last_idx) ? last_idx : step_q - AW'(1);
        end
    end

    always_comb begin
        pc_d   = pc_q;
        step_d = step_q;
        tick_d = 1'b0;
        pat_d  = '0;
        if (ena) begin
            pat_d = table_q[step_q];
            if (clr) begin
                pc_d   = '0;
                step_d = '0;
            end else if (!run) begin
                pc_d = '0;
            end else if (pc_q >= div) begin
                // >= rather than == so a shrinking div never wraps the prescaler.
                pc_d   = '0;
                step_d = next_step;
                tick_d = 1'b1;
            end else begin
                pc_d = pc_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= '0;
            step_q <= '0;
            tick_q <= 1'b0;
            pat_q  <= '0;
        end else begin
            pc_q   <= pc_d;
            step_q <= step_d;
            tick_q <= tick_d;
            pat_q  <= pat_d;
        end
    end

    assign pat_out   = pat_q;
    assign step_idx  = step_q;
    assign step_tick = tick_q;

endmodule

// File: tb/tb_pattern_seq.sv
// Bench for pattern_seq: a cycle-level reference model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_pattern_seq;

    logic        clk;
    logic        rst_n;
    logic        ena, run, dir, clr, wr_en;
    logic [2:0]  last_idx, wr_addr, step_idx;
    logic [15:0] div;
    logic [7:0]  wr_data, pat_out;
    logic        step_tick;

    int n_checks = 0;
    int n_errors = 0;

    int m_pc, m_idx, m_pat;
    int m_tick;
    int m_tab [8];

    int dflt [6] = '{8'h90, 8'h18, 8'h48, 8'h60, 8'h24, 8'h84};

    pattern_seq #(.WIDTH(8), .DEPTH(8), .DIV_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .run       (run),
        .dir       (dir),
        .clr       (clr),
        .last_idx  (last_idx),
        .div       (div),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .pat_out   (pat_out),
        .step_idx  (step_idx),
        .step_tick (step_tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Step order as a cyclic walk over 0..last; an index beyond last re-enters at the
    // start of the walk in the current direction.
    function automatic int next_idx(input int idx, input int last, input bit rev);
        if (!rev) return (idx > last) ? 0 : (idx + 1) % (last + 1);
        return (idx > last) ? last : (idx + last) % (last + 1);
    endfunction

    task automatic model_reset();
        m_pc = 0; m_idx = 0; m_tick = 0; m_pat = 0;
        for (int i = 0; i < 8; i++) m_tab[i] = (i < 6) ? dflt[i] : 0;
    endtask

    task automatic model_step();
        int nxt_pat;
        nxt_pat = ena ? m_tab[m_idx] : 0;
        m_tick = 0;
        if (ena) begin
            if (wr_en) m_tab[int'(wr_addr)] = int'(wr_data);
            if (clr) begin
                m_pc = 0;
                m_idx = 0;
            end else if (!run) begin
                m_pc = 0;
            end else if (m_pc >= int'(div)) begin
                m_pc = 0;
                m_idx = next_idx(m_idx, int'(last_idx), dir);
                m_tick = 1;
            end else begin
                m_pc = m_pc + 1;
            end
        end
        m_pat = nxt_pat;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("model_pat", pat_out, m_pat);
            chk("model_idx", step_idx, m_idx);
            chk("model_tick", step_tick, m_tick);
        end
    end

    initial begin
        logic [7:0] exp_pat [6];
        int seq [4];
        exp_pat = '{8'h90, 8'h18, 8'h48, 8'h60, 8'h24, 8'h84};
        seq = '{0, 5, 4, 3};

        rst_n = 1'b0; ena = 1'b1; run = 1'b1; dir = 1'b0; clr = 1'b0;
        last_idx = 3'd5; div = 16'd0; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_pat", pat_out, 0);
        chk("rst_idx", step_idx, 0);
        chk("rst_tick", step_tick, 0);
        rst_n = 1'b1;

        // div=0 forward: a new pattern and a tick every cycle
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            chk("seq_pat", pat_out, exp_pat[k % 6]);
            chk("seq_tick", step_tick, 1);
        end

        // div=3 reverse: each index held for four cycles
        div = 16'd3; dir = 1'b1; clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        for (int j = 0; j < 16; j++) begin
            if (j > 0) @(negedge clk);
            chk("rev_idx", step_idx, seq[j / 4]);
            chk("rev_tick", step_tick, (j > 0 && j % 4 == 0) ? 1 : 0);
        end

        // shrink last_idx while sitting at 5
        dir = 1'b0; div = 16'd0; clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        repeat (5) @(negedge clk);
        chk("at5_idx", step_idx, 5);
        last_idx = 3'd2;
        @(negedge clk);
        chk("shrink_fwd_idx", step_idx, 0);
        chk("shrink_fwd_tick", step_tick, 1);
        last_idx = 3'd5; dir = 1'b1;
        @(negedge clk);
        chk("wrap_rev_idx", step_idx, 5);
        last_idx = 3'd2;
        @(negedge clk);
        chk("shrink_rev_idx", step_idx, 2);
        chk("shrink_rev_tick", step_tick, 1);

        // write the entry currently being read
        dir = 1'b0; last_idx = 3'd5; clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        chk("wr_pre_idx", step_idx, 1);
        run = 1'b0; wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'hFF;
        @(negedge clk);
        wr_en = 1'b0;
        chk("wr_old_pat", pat_out, 8'h18);
        chk("wr_hold_tick", step_tick, 0);
        @(negedge clk);
        chk("wr_new_pat", pat_out, 8'hFF);
        chk("wr_hold_idx", step_idx, 1);

        // clr beats a tick in the same cycle
        run = 1'b1; clr = 1'b1;
        @(negedge clk);
        chk("clr_idx", step_idx, 0);
        chk("clr_tick", step_tick, 0);
        clr = 1'b0; div = 16'd3;
        repeat (2) @(negedge clk);
        // freeze with pc=2; the write must be ignored
        ena = 1'b0; wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'h55;
        @(negedge clk);
        wr_en = 1'b0;
        chk("frz_pat", pat_out, 0);
        chk("frz_tick", step_tick, 0);
        @(negedge clk);
        chk("frz_idx", step_idx, 0);
        ena = 1'b1;
        @(negedge clk);
        chk("resume_idx", step_idx, 0);
        chk("resume_pat", pat_out, 8'h90);
        @(negedge clk);
        chk("resume_tick_idx", step_idx, 1);
        chk("resume_tick", step_tick, 1);
        div = 16'd0;
        repeat (2) @(negedge clk);
        chk("write_ignored", pat_out, 8'h48);
        repeat (6) @(negedge clk);
        div = 16'd100;
        repeat (10) @(negedge clk);
        chk("pre_rst_idx", step_idx, 3);

        // asynchronous reset between clock edges
        #2 rst_n = 1'b0;
        #1;
        chk("arst_pat", pat_out, 0);
        chk("arst_idx", step_idx, 0);
        chk("arst_tick", step_tick, 0);
        @(negedge clk);
        rst_n = 1'b1; div = 16'd0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("restore_pat", pat_out, exp_pat[k]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pattern_seq.md
PATTERN_SEQ -- requirements
Module: pattern_seq

Interface
REQ-001 Parameter WIDTH, default 8, bit width of each output pattern.
REQ-002 Parameter DEPTH, default 8, number of pattern table entries; SHALL be a power of two, at least 2; AW = log2(DEPTH).
REQ-003 Parameter DIV_W, default 16, bit width of the step-period divider.
REQ-004 clk  in  1  clock; all state SHALL update on the rising edge only.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 ena  in  1  block enable; 0 freezes all state and blanks the output.
REQ-007 run  in  1  1 = sequence advances; 0 = sequence holds the current step.
REQ-008 dir  in  1  0 = forward step order; 1 = reverse step order.
REQ-009 clr  in  1  synchronous clear of the step index and the prescaler.
REQ-010 last_idx  in  AW  index of the final active step; active length = last_idx+1.
REQ-011 div  in  DIV_W  step period minus 1, in clk cycles.
REQ-012 wr_en  in  1  pattern table write strobe.
REQ-013 wr_addr  in  AW  pattern table write address.
REQ-014 wr_data  in  WIDTH  pattern table write data.
REQ-015 pat_out  out  WIDTH  registered pattern for the current step.
REQ-016 step_idx  out  AW  current step index.
REQ-017 step_tick  out  1  one-cycle pulse, asserted in the cycle step_idx takes a new value.

Function
REQ-018 Prescaler pc (DIV_W bits): when ena=1, run=1 and pc>=div, the block SHALL generate a tick and load pc<=0; when ena=1, run=1 and pc<div, pc<=pc+1.
REQ-019 The >= compare SHALL ensure that reducing div below the current pc mid-run produces a tick on the next cycle, with no wrap through 2^DIV_W.
REQ-020 On a tick with dir=0, step_idx <= 0 if step_idx>=last_idx, else step_idx+1.
REQ-021 On a tick with dir=1, step_idx <= last_idx if step_idx==0 or step_idx>last_idx, else step_idx-1.
REQ-022 With div=0 the block SHALL advance one step every cycle.
REQ-023 With run=0 and ena=1, pc SHALL load 0 and step_idx SHALL hold; raising run restarts a full period of div+1 cycles.
REQ-024 With clr=1 and ena=1, step_idx and pc SHALL load 0; no step_tick is generated; clr takes priority over a tick in the same cycle.
REQ-025 With ena=0, pc, step_idx and the pattern table SHALL hold, table writes SHALL be ignored, and step_tick SHALL be 0.
REQ-026 step_tick SHALL be registered and assert in the same cycle as the step_idx update caused by a tick, including when the new index equals the old one (last_idx=0).
REQ-027 Each cycle, pat_out SHALL load 0 if ena=0, else table[step_idx]; pat_out therefore lags step_idx by one cycle.
REQ-028 A table write (wr_en=1, ena=1) SHALL update table[wr_addr] at the clock edge; a simultaneous read of the same entry SHALL return the old value, and the new value SHALL appear on the following cycle.
REQ-029 Changing last_idx or dir mid-run SHALL take effect at the next tick, with no glitch or extra step_tick.

Reset
REQ-030 While rst_n=0: pc=0, step_idx=0, step_tick=0, pat_out=0.
REQ-031 On reset with WIDTH=8, table entries 0..5 SHALL be 0x90, 0x18, 0x48, 0x60, 0x24, 0x84 and the remaining entries 0x00; with any other WIDTH all entries SHALL be 0.
REQ-032 Asserting reset mid-sequence SHALL take effect immediately, without waiting for a clock edge.
REQ-033 After reset release with ena=1, run=1, the first tick SHALL occur div+1 cycles after release.

Verification
REQ-034 Reset, WIDTH=8, ena=1, run=1, dir=0, div=0, last_idx=5 -> pat_out sequence 0x90,0x18,0x48,0x60,0x24,0x84,0x90..., with step_tick high every cycle.
REQ-035 div=3, dir=1, last_idx=5 -> step_idx 0,5,4,3,...; each index held 4 cycles; step_tick spacing 4 cycles.
REQ-036 At step_idx=5, change last_idx to 2 with dir=0 -> next tick gives step_idx=0; with dir=1 -> next tick gives step_idx=2.
REQ-037 Write 0xFF to entry 1 while step_idx=1, ena=1, run=0 -> pat_out shows 0x18 for one cycle, then 0xFF.
REQ-038 clr and a tick in the same cycle -> step_idx=0, step_tick=0; ena=0 mid-run -> pat_out=0 next cycle, step_idx frozen; ena=1 -> resumes from the frozen index and pc.
REQ-039 Assert rst_n=0 asynchronously mid-period with div=100 -> all outputs 0 without a clock edge; table restored to the REQ-031 defaults.
